// File: rtl/dcache_array_arbiter_pkg.sv
// rtl/dcache_array_arbiter_pkg.sv - dcache array command/response types and arbiter constants
package dcache_array_arbiter_pkg;

  localparam int DCACHE_ARB_NREQ       = 3;
  localparam int DCACHE_ARB_STARVE_MAX = 8;

  typedef struct packed {
    logic        we;
    logic [5:0]  idx;
    logic [19:0] tag;
  } tag_req_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] tag;
  } tag_rsp_t;

  typedef struct packed {
    logic        we;
    logic [5:0]  idx;
    logic [3:0]  be;
    logic [31:0] wdata;
  } data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } data_rsp_t;

  typedef enum logic [1:0] {
    ARB_REFILL = 2'd0,
    ARB_STORE  = 2'd1,
    ARB_LOAD   = 2'd2
  } arb_src_e;

  typedef struct packed {
    logic     is_read;
    arb_src_e src;
  } arb_pipe_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dcache_array_arbiter_rsp_pipe.sv
// rtl/dcache_array_arbiter_rsp_pipe.sv - fixed-latency read-owner pipe decoding to per-requester rsp_valid
module dcache_arb_rsp_pipe
  import dcache_array_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int NREQ   = DCACHE_ARB_NREQ
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  arb_pipe_t       push_i,
  output logic [NREQ-1:0] rsp_valid_o
);

  arb_pipe_t stage_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Masked during reset so reads issued before reset never surface.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_i && stage_q[RD_LAT-1].is_read && (int'(stage_q[RD_LAT-1].src) == i))
        rsp_valid_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/dcache_array_arbiter.sv
// rtl/dcache_array_arbiter.sv - shares dcache tag/data arrays between refill, store drain and load pipe
module dcache_array_arbiter
  import dcache_array_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = DCACHE_ARB_STARVE_MAX,
  parameter int NREQ       = DCACHE_ARB_NREQ
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic      [NREQ-1:0]   req_valid_i,
  output logic      [NREQ-1:0]   req_ready_o,
  input  tag_req_t  [NREQ-1:0]   req_tag_i,
  input  logic      [NREQ-1:0]   req_tag_en_i,
  input  data_req_t [NREQ-1:0]   req_data_i,
  input  logic      [NREQ-1:0]   req_data_en_i,
  input  logic                   refill_lock_i,
  output tag_req_t               tag_req_o,
  output logic                   tag_req_valid_o,
  output data_req_t              data_req_o,
  output logic                   data_req_valid_o,
  input  tag_rsp_t               tag_rsp_i,
  input  data_rsp_t              data_rsp_i,
  output logic      [NREQ-1:0]   rsp_valid_o,
  output tag_rsp_t               tag_rsp_o,
  output data_rsp_t              data_rsp_o,
  output logic                   lock_active_o
);

  localparam int              CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

  lock_state_e     state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [NREQ-1:0] grant;
  logic            starved;
  arb_pipe_t       push;

  assign starved = (starve_q == STARVE_LIM);

  always_comb begin
    grant   = '0;
    state_d = state_q;
    if (!rst_i) begin
      // While locked and the refill still holds the lock, nobody but refill may win.
      if (state_q == LOCKED && refill_lock_i)       grant[ARB_REFILL] = req_valid_i[ARB_REFILL];
      else if (req_valid_i[ARB_REFILL])             grant[ARB_REFILL] = 1'b1;
      else if (starved && req_valid_i[ARB_LOAD])    grant[ARB_LOAD]   = 1'b1;
      else if (req_valid_i[ARB_STORE])              grant[ARB_STORE]  = 1'b1;
      else if (req_valid_i[ARB_LOAD])               grant[ARB_LOAD]   = 1'b1;

      case (state_q)
        UNLOCKED: if (grant[ARB_REFILL] && refill_lock_i) state_d = LOCKED;
        LOCKED:   if (!refill_lock_i)                     state_d = UNLOCKED;
        default:                                          state_d = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    starve_d = '0;
    if (req_valid_i[ARB_LOAD] && !grant[ARB_LOAD])
      starve_d = starved ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= UNLOCKED;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    tag_req_o        = '0;
    data_req_o       = '0;
    tag_req_valid_o  = 1'b0;
    data_req_valid_o = 1'b0;
    push             = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        tag_req_o        = req_tag_i[i];
        data_req_o       = req_data_i[i];
        tag_req_valid_o  = req_tag_en_i[i];
        data_req_valid_o = req_data_en_i[i];
        push.src         = arb_src_e'(i[1:0]);
      end
    end
    push.is_read = (tag_req_valid_o && !tag_req_o.we) || (data_req_valid_o && !data_req_o.we);
  end

  dcache_arb_rsp_pipe #(
    .RD_LAT (RD_LAT),
    .NREQ   (NREQ)
  ) u_rsp_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .rsp_valid_o (rsp_valid_o)
  );

  assign req_ready_o   = grant;
  assign tag_rsp_o     = tag_rsp_i;
  assign data_rsp_o    = data_rsp_i;
  assign lock_active_o = (state_q == LOCKED);

endmodule

// File: tb/tb_dcache_array_arbiter.sv
// tb/tb_dcache_array_arbiter.sv - directed and randomized checks of dcache_array_arbiter against a reference model
module tb_dcache_array_arbiter;
  import dcache_array_arbiter_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;
  localparam int NREQ       = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid, req_ready, tag_en, data_en, rsp_valid;
  tag_req_t  [2:0] req_tag;
  data_req_t [2:0] req_data;
  logic            refill_lock;
  tag_req_t        tag_req;
  logic            tag_req_valid;
  data_req_t       data_req;
  logic            data_req_valid;
  tag_rsp_t        tag_rsp_in, tag_rsp_out;
  data_rsp_t       data_rsp_in, data_rsp_out;
  logic            lock_active;

  int checks = 0;
  int passes = 0;

  bit         m_locked;
  int         m_starve;
  logic [2:0] m_pipe[$];

  always #5 clk = ~clk;

  dcache_array_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX), .NREQ(NREQ)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_tag_i        (req_tag),
    .req_tag_en_i     (tag_en),
    .req_data_i       (req_data),
    .req_data_en_i    (data_en),
    .refill_lock_i    (refill_lock),
    .tag_req_o        (tag_req),
    .tag_req_valid_o  (tag_req_valid),
    .data_req_o       (data_req),
    .data_req_valid_o (data_req_valid),
    .tag_rsp_i        (tag_rsp_in),
    .data_rsp_i       (data_rsp_in),
    .rsp_valid_o      (rsp_valid),
    .tag_rsp_o        (tag_rsp_out),
    .data_rsp_o       (data_rsp_out),
    .lock_active_o    (lock_active)
  );

  function automatic logic [2:0] model_grant();
    int         order[3];
    logic [2:0] allow;
    if (rst) return 3'b000;
    allow = (m_locked && refill_lock) ? 3'b001 : 3'b111;
    if (m_starve >= STARVE_MAX) order = '{0, 2, 1};
    else                        order = '{0, 1, 2};
    foreach (order[k])
      if (req_valid[order[k]] && allow[order[k]]) return 3'b001 << order[k];
    return 3'b000;
  endfunction

  function automatic logic model_is_read(logic [2:0] g);
    for (int i = 0; i < 3; i++)
      if (g[i]) return (tag_en[i] && !req_tag[i].we) || (data_en[i] && !req_data[i].we);
    return 1'b0;
  endfunction

  function automatic logic [2:0] model_rsp();
    return rst ? 3'b000 : m_pipe[0];
  endfunction

  task automatic tick();
    logic [2:0] g;
    logic       rd;
    g  = model_grant();
    rd = model_is_read(g);
    @(posedge clk);
    if (rst) begin
      m_locked = 0;
      m_starve = 0;
      foreach (m_pipe[i]) m_pipe[i] = 3'b000;
    end else begin
      if (m_locked) m_locked = refill_lock;
      else          m_locked = g[0] && refill_lock;
      if (req_valid[2] && !g[2]) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else                       m_starve = 0;
      void'(m_pipe.pop_front());
      m_pipe.push_back(rd ? g : 3'b000);
    end
    #1;
  endtask

  task automatic set_idle();
    req_valid   = 3'b000;
    tag_en      = 3'b000;
    data_en     = 3'b000;
    refill_lock = 1'b0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 3; i++) begin
      req_tag[i].we     = 1'($urandom_range(0, 1));
      req_tag[i].idx    = 6'($urandom);
      req_tag[i].tag    = 20'($urandom);
      req_data[i].we    = 1'($urandom_range(0, 1));
      req_data[i].idx   = 6'($urandom);
      req_data[i].be    = 4'($urandom);
      req_data[i].wdata = $urandom;
    end
    tag_rsp_in.valid  = 1'($urandom_range(0, 1));
    tag_rsp_in.tag    = 20'($urandom);
    data_rsp_in.rdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 3'b111;
    tag_en = 3'b111;
    data_en = 3'b111;
    tick();
    tick();
    #3;
    checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got=%b exp=000", req_ready); else passes++;
    checks++; if (tag_req_valid !== 1'b0) $display("FAIL reset_tag_valid got=%b exp=0", tag_req_valid); else passes++;
    checks++; if (data_req_valid !== 1'b0) $display("FAIL reset_data_valid got=%b exp=0", data_req_valid); else passes++;
    checks++; if (rsp_valid !== 3'b000) $display("FAIL reset_rsp got=%b exp=000", rsp_valid); else passes++;
    checks++; if (lock_active !== 1'b0) $display("FAIL reset_lock got=%b exp=0", lock_active); else passes++;
    checks++; if (tag_req !== '0 || data_req !== '0) $display("FAIL reset_req_bus got=%h/%h exp=0", tag_req, data_req); else passes++;
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_load_read();
    set_idle();
    req_valid = 3'b100;
    tag_en = 3'b100;
    req_tag[2].idx = 6'd5;
    req_tag[2].we = 1'b0;
    #3;
    checks++; if (req_ready !== 3'b100) $display("FAIL load_ready got=%b exp=100", req_ready); else passes++;
    checks++; if (tag_req_valid !== 1'b1) $display("FAIL load_tag_valid got=%b exp=1", tag_req_valid); else passes++;
    checks++; if (tag_req.idx !== 6'd5) $display("FAIL load_idx got=%0d exp=5", tag_req.idx); else passes++;
    checks++; if (data_req_valid !== 1'b0) $display("FAIL load_data_valid got=%b exp=0", data_req_valid); else passes++;
    tick();
    set_idle();
    #3;
    checks++; if (rsp_valid !== 3'b100) $display("FAIL load_rsp got=%b exp=100", rsp_valid); else passes++;
    tick();
    #3;
    checks++; if (rsp_valid !== 3'b000) $display("FAIL load_rsp_once got=%b exp=000", rsp_valid); else passes++;
    tick();
  endtask

  task automatic test_simultaneous();
    rand_fields();
    set_idle();
    req_valid = 3'b111;
    tag_en = 3'b111;
    #3;
    checks++; if (req_ready !== 3'b001) $display("FAIL simul_refill got=%b exp=001", req_ready); else passes++;
    checks++; if (tag_req !== req_tag[0]) $display("FAIL simul_mux got=%h exp=%h", tag_req, req_tag[0]); else passes++;
    tick();
    req_valid = 3'b110;
    #3;
    checks++; if (req_ready !== 3'b010) $display("FAIL simul_store got=%b exp=010", req_ready); else passes++;
    checks++; if (tag_req !== req_tag[1]) $display("FAIL simul_mux_store got=%h exp=%h", tag_req, req_tag[1]); else passes++;
    tick();
    req_valid = 3'b100;
    #3;
    checks++; if (req_ready !== 3'b100) $display("FAIL simul_load got=%b exp=100", req_ready); else passes++;
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_starvation();
    logic [2:0] exp;
    set_idle();
    req_valid = 3'b110;
    data_en = 3'b110;
    req_data[1].we = 1'b1;
    req_data[2].we = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      #3;
      exp = (c == 9) ? 3'b100 : 3'b010;
      checks++; if (req_ready !== exp) $display("FAIL starve_cycle%0d got=%b exp=%b", c, req_ready, exp); else passes++;
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_lock();
    set_idle();
    req_valid = 3'b111;
    refill_lock = 1'b1;
    data_en = 3'b111;
    req_data[0].we = 1'b1;
    req_data[1].we = 1'b1;
    req_data[2].we = 1'b0;
    for (int b = 1; b <= 16; b++) begin
      #3;
      checks++; if (req_ready !== 3'b001) $display("FAIL lock_beat%0d_ready got=%b exp=001", b, req_ready); else passes++;
      checks++; if (rsp_valid !== 3'b000) $display("FAIL lock_beat%0d_rsp got=%b exp=000", b, rsp_valid); else passes++;
      checks++; if (lock_active !== (b > 1)) $display("FAIL lock_beat%0d_active got=%b exp=%b", b, lock_active, (b > 1)); else passes++;
      tick();
    end
    refill_lock = 1'b0;
    req_valid = 3'b110;
    tag_en = 3'b100;
    req_tag[2].we = 1'b0;
    #3;
    checks++; if (req_ready !== 3'b100) $display("FAIL lock_release_load got=%b exp=100", req_ready); else passes++;
    checks++; if (lock_active !== 1'b1) $display("FAIL lock_release_active got=%b exp=1", lock_active); else passes++;
    tick();
    set_idle();
    #3;
    checks++; if (lock_active !== 1'b0) $display("FAIL lock_dropped got=%b exp=0", lock_active); else passes++;
    checks++; if (rsp_valid !== 3'b100) $display("FAIL lock_release_rsp got=%b exp=100", rsp_valid); else passes++;
    tick();
  endtask

  task automatic test_alternate();
    logic       prev_load;
    logic [2:0] exp_rsp;
    set_idle();
    tag_en = 3'b110;
    data_en = 3'b010;
    req_tag[1].we = 1'b1;
    req_data[1].we = 1'b1;
    req_tag[2].we = 1'b0;
    prev_load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_valid = (i % 2 == 1) ? 3'b100 : 3'b010;
      #3;
      exp_rsp = prev_load ? 3'b100 : 3'b000;
      checks++; if (req_ready !== req_valid) $display("FAIL alt%0d_ready got=%b exp=%b", i, req_ready, req_valid); else passes++;
      checks++; if (rsp_valid !== exp_rsp) $display("FAIL alt%0d_rsp got=%b exp=%b", i, rsp_valid, exp_rsp); else passes++;
      prev_load = (i % 2 == 1);
      tick();
    end
    set_idle();
    #3;
    checks++; if (rsp_valid !== 3'b100) $display("FAIL alt_last_rsp got=%b exp=100", rsp_valid); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    set_idle();
    req_valid = 3'b001;
    refill_lock = 1'b1;
    tag_en = 3'b101;
    req_tag[0].we = 1'b0;
    req_tag[2].we = 1'b0;
    #3;
    checks++; if (req_ready !== 3'b001) $display("FAIL rmid_refill got=%b exp=001", req_ready); else passes++;
    tick();
    req_valid = 3'b100;
    refill_lock = 1'b0;
    #3;
    checks++; if (lock_active !== 1'b1) $display("FAIL rmid_locked got=%b exp=1", lock_active); else passes++;
    checks++; if (req_ready !== 3'b100) $display("FAIL rmid_load got=%b exp=100", req_ready); else passes++;
    checks++; if (rsp_valid !== 3'b001) $display("FAIL rmid_refill_rsp got=%b exp=001", rsp_valid); else passes++;
    tick();
    rst = 1'b1;
    req_valid = 3'b001;
    refill_lock = 1'b1;
    #3;
    checks++; if (rsp_valid !== 3'b000) $display("FAIL rmid_rsp_in_reset got=%b exp=000", rsp_valid); else passes++;
    checks++; if (req_ready !== 3'b000) $display("FAIL rmid_ready_in_reset got=%b exp=000", req_ready); else passes++;
    tick();
    rst = 1'b0;
    set_idle();
    #3;
    checks++; if (rsp_valid !== 3'b000) $display("FAIL rmid_rsp_after got=%b exp=000", rsp_valid); else passes++;
    checks++; if (lock_active !== 1'b0) $display("FAIL rmid_lock_after got=%b exp=0", lock_active); else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [2:0] exp_g, exp_rsp;
    tag_req_t   exp_tag;
    data_req_t  exp_data;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      req_valid   = 3'($urandom);
      refill_lock = ($urandom_range(0, 3) == 0);
      tag_en      = 3'($urandom);
      data_en     = 3'($urandom);
      rand_fields();
      #3;
      exp_g   = model_grant();
      exp_rsp = model_rsp();
      exp_tag = '0;
      exp_data = '0;
      for (int i = 0; i < 3; i++)
        if (exp_g[i]) begin exp_tag = req_tag[i]; exp_data = req_data[i]; end
      checks++; if (req_ready !== exp_g) $display("FAIL rnd%0d_ready got=%b exp=%b", n, req_ready, exp_g); else passes++;
      checks++; if (rsp_valid !== exp_rsp) $display("FAIL rnd%0d_rsp got=%b exp=%b", n, rsp_valid, exp_rsp); else passes++;
      checks++; if (tag_req_valid !== |(exp_g & tag_en)) $display("FAIL rnd%0d_tag_valid got=%b exp=%b", n, tag_req_valid, |(exp_g & tag_en)); else passes++;
      checks++; if (data_req_valid !== |(exp_g & data_en)) $display("FAIL rnd%0d_data_valid got=%b exp=%b", n, data_req_valid, |(exp_g & data_en)); else passes++;
      if (exp_g != 3'b000) begin
        checks++; if (tag_req !== exp_tag) $display("FAIL rnd%0d_tag_req got=%h exp=%h", n, tag_req, exp_tag); else passes++;
        checks++; if (data_req !== exp_data) $display("FAIL rnd%0d_data_req got=%h exp=%h", n, data_req, exp_data); else passes++;
      end
      if (!rst) begin
        checks++; if (lock_active !== m_locked) $display("FAIL rnd%0d_lock got=%b exp=%b", n, lock_active, m_locked); else passes++;
      end
      checks++; if (tag_rsp_out !== tag_rsp_in || data_rsp_out !== data_rsp_in) $display("FAIL rnd%0d_passthru got=%h/%h exp=%h/%h", n, tag_rsp_out, data_rsp_out, tag_rsp_in, data_rsp_in); else passes++;
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_idle();
    rand_fields();
    m_locked = 0;
    m_starve = 0;
    for (int i = 0; i < RD_LAT; i++) m_pipe.push_back(3'b000);
    test_reset();
    test_load_read();
    test_simultaneous();
    test_starvation();
    test_lock();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
